mc_core: RTL and testbench
==========================

// Module: mc_core
// PURPOSE
//  Parametrised multi-cycle successor of the single-cycle core top. Same MIPS-style
//  32-bit instruction format; adds imem/dmem request/ack handshakes, load/store, a
//  halt state and a retire strobe. Sits between the instruction/data memories and
//  the host debug interface.
// PARAMETERS
//  WIDTH     32  datapath/register width; legal 32 or 64; instructions always 32 bit
//  NREG      32  integer registers; power of two, 2..32; r0 reads as 0
//  PC_RESET  0   PC value after reset
// PORTS
//  clk           in   1          clock; all state changes on rising edge
//  rst           in   1          synchronous reset, active-high
//  imem_req      out  1          fetch request; high iff state==FETCH and rst low
//  imem_addr     out  WIDTH      byte address of fetch (= PC)
//  imem_valid    in   1          fetch data valid; sampled only while imem_req high
//  imem_data     in   32         instruction word
//  dmem_req      out  1          data request; high iff state==MEM
//  dmem_we       out  1          1 = store (sw), 0 = load (lw)
//  dmem_addr     out  WIDTH      rs + sext(immd)
//  dmem_wdata    out  WIDTH      rt value for sw
//  dmem_ack      in   1          data done; rdata valid in the same cycle
//  dmem_rdata    in   WIDTH      load data
//  program_counter out WIDTH     current PC
//  link_register out  WIDTH      LR (separate from register file)
//  regnum        in   log2(NREG) debug read index
//  reggg         out  WIDTH      combinational read of register regnum
//  retire        out  1          one-cycle pulse in the WB cycle of every instruction
//  halted        out  1          high in HALT
// BEHAVIOUR
//  Reset: state=FETCH, PC=PC_RESET, LR=0, all registers=0, IR=0; imem_req/dmem_req/
//   retire/halted=0 while rst high. Reset mid-handshake abandons the request.
//  Fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] immd[15:0]
//   addr[25:0]. Register indices are taken modulo NREG.
//  FSM: FETCH --imem_valid--> EXEC (IR captured) ; EXEC -> MEM (lw/sw) or WB ;
//   MEM --dmem_ack--> WB ; WB -> FETCH ; EXEC with undefined op/funct -> HALT.
//   HALT is left only by rst. Zero-wait memory: ALU/branch 3 cycles, lw/sw 4.
//  Handshake: address/we/wdata held stable while req high; ack/valid same cycle as
//   req accepted; valid/ack seen while req low are ignored.
//  EXEC computes ALU result, branch decision and next PC; WB commits reg/LR/PC.
//  R-type (op 0), funct: 20 add, 22 sub, 24 and, 25 or, 2A slt (signed), 00 sll,
//   02 srl (by shamt), 08 jr (PC=rs), 09 jrl (PC=LR). Result to rd.
//  I-type: 08 addi (sext), 0D ori (zext), 23 lw rt=mem, 2B sw, 04 beq, 05 bne.
//  J-type: 02 j, 03 jal (LR=PC+4). Target = {PC+4[WIDTH-1:28], addr, 2'b00}.
//  Branch target = PC+4 + (sext(immd)<<2); otherwise PC=PC+4. Arithmetic wraps mod
//   2^WIDTH; no overflow trap. Writes to r0 discarded; r0 always reads 0.
//  Register reads in EXEC use values committed in the previous WB (no hazard logic).
//  reggg reflects a WB write from the cycle after the WB edge.
//  retire asserted only in WB; not asserted for the instruction that halts.
// TESTING
//  rst high 2 cycles, release -> imem_req=1, imem_addr=0, all regs/LR=0, halted=0.
//  addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 zero-wait -> r3=2, retire every 3 cycles.
//  imem_valid delayed 4 cycles -> imem_addr stable, IR captured on valid, no retire early.
//  sw r1,8(r0) then lw r4,8(r0), ack after 2 cycles -> dmem_we 1 then 0, addr 8, r4=5.
//  beq r0,r0,+2 at PC 0x10 -> next fetch 0x1C; jal at 0x20 -> LR=0x24; jrl -> fetch 0x24.
//  op 0x3F -> halted=1, no retire, no further imem_req; rst mid-MEM -> dmem_req drops.

Source files
------------

// File: rtl/mc_core.sv
// Multi-cycle MIPS-style core: FETCH/EXEC/MEM/WB/HALT sequencer with imem/dmem
// request-acknowledge handshakes, separate link register and debug register read.
module mc_core #(
    parameter int                 WIDTH    = 32,
    parameter int                 NREG     = 32,
    parameter logic [WIDTH-1:0]   PC_RESET = {WIDTH{1'b0}},
    localparam int                RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] program_counter,
    output logic [WIDTH-1:0] link_register,
    input  logic [RW-1:0]    regnum,
    output logic [WIDTH-1:0] reggg,
    output logic             retire,
    output logic             halted
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] FOUR_W = {{(WIDTH-3){1'b0}}, 3'b100};
    localparam logic [RW-1:0]    ZERO_R = {RW{1'b0}};

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] lr_q;
    logic [31:0]      ir_q;
    logic [WIDTH-1:0] regs_q [NREG];

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] npc_q;
    logic [RW-1:0]    dst_q;
    logic             wen_q;
    logic             lr_we_q;

    logic             imem_req_q;
    logic             dmem_req_q;
    logic             dmem_we_q;
    logic [WIDTH-1:0] dmem_addr_q;
    logic [WIDTH-1:0] dmem_wdata_q;
    logic             retire_q;
    logic             halted_q;

    logic [5:0]       op_s;
    logic [5:0]       funct_s;
    logic [4:0]       shamt_s;
    logic [RW-1:0]    rs_idx_s;
    logic [RW-1:0]    rt_idx_s;
    logic [RW-1:0]    rd_idx_s;
    logic [WIDTH-1:0] rs_val_s;
    logic [WIDTH-1:0] rt_val_s;
    logic [WIDTH-1:0] sext_s;
    logic [WIDTH-1:0] zext_s;
    logic [WIDTH-1:0] pc4_s;
    logic [WIDTH-1:0] btarget_s;
    logic [WIDTH-1:0] jtarget_s;
    logic [WIDTH-1:0] mem_addr_s;

    logic [WIDTH-1:0] ex_res_d;
    logic [WIDTH-1:0] ex_npc_d;
    logic [RW-1:0]    ex_dst_d;
    logic             ex_wen_d;
    logic             ex_lr_we_d;
    logic             ex_mem_d;
    logic             ex_we_d;
    logic             ex_illegal_d;

    // Register indices wrap modulo NREG by keeping only the low RW bits of each field.
    assign op_s     = ir_q[31:26];
    assign funct_s  = ir_q[5:0];
    assign shamt_s  = ir_q[10:6];
    assign rs_idx_s = ir_q[21 +: RW];
    assign rt_idx_s = ir_q[16 +: RW];
    assign rd_idx_s = ir_q[11 +: RW];

    assign rs_val_s   = (rs_idx_s == ZERO_R) ? ZERO_W : regs_q[rs_idx_s];
    assign rt_val_s   = (rt_idx_s == ZERO_R) ? ZERO_W : regs_q[rt_idx_s];
    assign sext_s     = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign zext_s     = {{(WIDTH-16){1'b0}}, ir_q[15:0]};
    assign pc4_s      = pc_q + FOUR_W;
    assign btarget_s  = pc4_s + (sext_s << 2);
    assign jtarget_s  = {pc4_s[WIDTH-1:28], ir_q[25:0], 2'b00};
    assign mem_addr_s = rs_val_s + sext_s;

    // Decode the held instruction into its result, destination and next PC.
    always_comb begin
        ex_res_d     = ZERO_W;
        ex_npc_d     = pc4_s;
        ex_dst_d     = rd_idx_s;
        ex_wen_d     = 1'b0;
        ex_lr_we_d   = 1'b0;
        ex_mem_d     = 1'b0;
        ex_we_d      = 1'b0;
        ex_illegal_d = 1'b0;
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h20: begin ex_res_d = rs_val_s + rt_val_s; ex_wen_d = 1'b1; end
                    6'h22: begin ex_res_d = rs_val_s - rt_val_s; ex_wen_d = 1'b1; end
                    6'h24: begin ex_res_d = rs_val_s & rt_val_s; ex_wen_d = 1'b1; end
                    6'h25: begin ex_res_d = rs_val_s | rt_val_s; ex_wen_d = 1'b1; end
                    6'h2A: begin
                        ex_res_d = {{(WIDTH-1){1'b0}}, ($signed(rs_val_s) < $signed(rt_val_s))};
                        ex_wen_d = 1'b1;
                    end
                    6'h00: begin ex_res_d = rt_val_s << shamt_s; ex_wen_d = 1'b1; end
                    6'h02: begin ex_res_d = rt_val_s >> shamt_s; ex_wen_d = 1'b1; end
                    6'h08: ex_npc_d = rs_val_s;
                    6'h09: ex_npc_d = lr_q;
                    default: ex_illegal_d = 1'b1;
                endcase
            end
            6'h08: begin
                ex_res_d = rs_val_s + sext_s;
                ex_dst_d = rt_idx_s;
                ex_wen_d = 1'b1;
            end
            6'h0D: begin
                ex_res_d = rs_val_s | zext_s;
                ex_dst_d = rt_idx_s;
                ex_wen_d = 1'b1;
            end
            6'h23: begin
                ex_mem_d = 1'b1;
                ex_dst_d = rt_idx_s;
                ex_wen_d = 1'b1;
            end
            6'h2B: begin
                ex_mem_d = 1'b1;
                ex_we_d  = 1'b1;
            end
            6'h04: ex_npc_d = (rs_val_s == rt_val_s) ? btarget_s : pc4_s;
            6'h05: ex_npc_d = (rs_val_s != rt_val_s) ? btarget_s : pc4_s;
            6'h02: ex_npc_d = jtarget_s;
            6'h03: begin
                ex_npc_d   = jtarget_s;
                ex_lr_we_d = 1'b1;
            end
            default: ex_illegal_d = 1'b1;
        endcase
    end

    // Sequencer, architectural state and registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= PC_RESET;
            lr_q         <= ZERO_W;
            ir_q         <= 32'h0000_0000;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= ZERO_W;
            end
            res_q        <= ZERO_W;
            npc_q        <= ZERO_W;
            dst_q        <= ZERO_R;
            wen_q        <= 1'b0;
            lr_we_q      <= 1'b0;
            imem_req_q   <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= ZERO_W;
            dmem_wdata_q <= ZERO_W;
            retire_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_q       <= imem_data;
                        imem_req_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ex_illegal_d) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        res_q        <= ex_res_d;
                        npc_q        <= ex_npc_d;
                        dst_q        <= ex_dst_d;
                        wen_q        <= ex_wen_d;
                        lr_we_q      <= ex_lr_we_d;
                        dmem_we_q    <= ex_we_d;
                        dmem_addr_q  <= mem_addr_s;
                        dmem_wdata_q <= rt_val_s;
                        if (ex_mem_d) begin
                            dmem_req_q <= 1'b1;
                            state_q    <= S_MEM;
                        end else begin
                            retire_q <= 1'b1;
                            state_q  <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we_q) begin
                            res_q <= dmem_rdata;
                        end
                        dmem_req_q <= 1'b0;
                        retire_q   <= 1'b1;
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    if (wen_q && (dst_q != ZERO_R)) begin
                        regs_q[dst_q] <= res_q;
                    end
                    if (lr_we_q) begin
                        lr_q <= pc4_s;
                    end
                    pc_q       <= npc_q;
                    retire_q   <= 1'b0;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    retire_q   <= 1'b0;
                    halted_q   <= 1'b1;
                    state_q    <= S_HALT;
                end
            endcase
        end
    end

    // Reset must silence every strobe in the same cycle, abandoning any open request.
    assign imem_req        = imem_req_q & ~rst;
    assign dmem_req        = dmem_req_q & ~rst;
    assign retire          = retire_q & ~rst;
    assign halted          = halted_q & ~rst;
    assign imem_addr       = pc_q;
    assign dmem_we         = dmem_we_q;
    assign dmem_addr       = dmem_addr_q;
    assign dmem_wdata      = dmem_wdata_q;
    assign program_counter = pc_q;
    assign link_register   = lr_q;
    assign reggg           = (regnum == ZERO_R) ? ZERO_W : regs_q[regnum];

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: instruction/memory responder with expected
// fetch PCs, memory requests and register results queued ahead of each step.
module tb_mc_core;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] program_counter;
    logic [31:0] link_register;
    logic [4:0]  regnum;
    logic [31:0] reggg;
    logic        retire;
    logic        halted;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] pc;
        bit          chk_reg;
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    exp_t  sb[$];
    mexp_t mq[$];

    mc_core dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_data       (imem_data),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .program_counter (program_counter),
        .link_register   (link_register),
        .regnum          (regnum),
        .reggg           (reggg),
        .retire          (retire),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic expect_i(input logic [31:0] pc, input bit cr, input logic [4:0] idx,
                            input logic [31:0] val);
        exp_t e;
        e.pc = pc; e.chk_reg = cr; e.idx = idx; e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_m(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mexp_t m;
        m.we = we; m.addr = addr; m.wdata = wdata;
        mq.push_back(m);
    endtask

    // Serve one instruction: fetch (optionally delayed), answer dmem, then score.
    task automatic step(input logic [31:0] instr, input int vdelay, input int adelay,
                        input logic [31:0] rdata, input int exp_lat, input bit exp_halt);
        exp_t  e;
        mexp_t m;
        int    n;
        int    lat;
        int    wcnt;
        bit    done;
        bit    mem_seen;
        e = sb.pop_front();
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", imem_req, 1'b1);
        chk("imem_addr", imem_addr, e.pc);
        for (int i = 0; i < vdelay; i++) begin
            @(negedge clk);
            chk("fetch_hold", {imem_req, retire, imem_addr}, {1'b1, 1'b0, e.pc});
        end
        imem_valid = 1'b1;
        imem_data  = instr;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'hFFFF_FFFF;
        lat = 1; wcnt = 0; done = 1'b0; mem_seen = 1'b0;
        while (!done && lat < 40) begin
            if (retire || halted) begin
                done = 1'b1;
            end else begin
                if (dmem_req) begin
                    if (!mem_seen) begin
                        m = mq.pop_front();
                        mem_seen = 1'b1;
                    end
                    chk("dmem_req_fields", {dmem_we, dmem_addr, dmem_wdata}, {m.we, m.addr, m.wdata});
                    if (wcnt == adelay) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = rdata;
                    end else begin
                        wcnt++;
                    end
                end
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = 32'hDEAD_BEEF;
                lat++;
            end
        end
        chk("latency", lat, exp_lat);
        chk("retire_halt", {retire, halted}, {~exp_halt, exp_halt});
        @(negedge clk);
        if (e.chk_reg) begin
            regnum = e.idx;
            #1;
            chk("reg_value", reggg, e.val);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; imem_valid = 1'b0; imem_data = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0; regnum = 5'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {imem_req, dmem_req, retire, halted}, 4'b0000);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {imem_req, halted}, 2'b10);
        chk("post_rst_pc", {imem_addr, program_counter, link_register}, 96'h0);
        regnum = 5'd1;
        #1;
        chk("post_rst_r1", reggg, 32'h0);
        regnum = 5'd31;
        #1;
        chk("post_rst_r31", reggg, 32'h0);
        @(negedge clk);

        expect_i(32'h00, 1'b1, 5'd1, 32'd5);
        step(itype(6'h08, 5'd0, 5'd1, 16'd5), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFD);
        step(itype(6'h08, 5'd0, 5'd2, 16'hFFFD), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h08, 1'b1, 5'd3, 32'd2);
        step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h0C, 1'b0, 5'd0, 32'h0);
        expect_m(1'b1, 32'd8, 32'd5);
        step(itype(6'h2B, 5'd0, 5'd1, 16'd8), 0, 2, 32'h0, 5, 1'b0);
        expect_i(32'h10, 1'b0, 5'd0, 32'h0);
        step(itype(6'h04, 5'd0, 5'd0, 16'd2), 4, 0, 32'h0, 2, 1'b0);
        expect_i(32'h1C, 1'b1, 5'd4, 32'd5);
        expect_m(1'b0, 32'd8, 32'd0);
        step(itype(6'h23, 5'd0, 5'd4, 16'd8), 0, 2, 32'd5, 5, 1'b0);
        expect_i(32'h20, 1'b0, 5'd0, 32'h0);
        step({6'h03, 26'h10}, 0, 0, 32'h0, 2, 1'b0);
        chk("jal_lr", link_register, 32'h24);
        expect_i(32'h40, 1'b1, 5'd5, 32'd8);
        step(rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h22), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h44, 1'b1, 5'd6, 32'd1);
        step(rtype(5'd2, 5'd1, 5'd6, 5'd0, 6'h2A), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h48, 1'b1, 5'd7, 32'h50);
        step(rtype(5'd0, 5'd1, 5'd7, 5'd4, 6'h00), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h4C, 1'b1, 5'd8, 32'hF);
        step(rtype(5'd0, 5'd2, 5'd8, 5'd28, 6'h02), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h50, 1'b1, 5'd9, 32'h0000_F00F);
        step(itype(6'h0D, 5'd0, 5'd9, 16'hF00F), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h54, 1'b1, 5'd10, 32'd5);
        step(rtype(5'd9, 5'd1, 5'd10, 5'd0, 6'h24), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h58, 1'b1, 5'd11, 32'hFFFF_FFFF);
        step(rtype(5'd9, 5'd2, 5'd11, 5'd0, 6'h25), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h5C, 1'b0, 5'd0, 32'h0);
        step(itype(6'h05, 5'd1, 5'd1, 16'd4), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h60, 1'b0, 5'd0, 32'h0);
        step(rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h09), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h24, 1'b1, 5'd0, 32'h0);
        step(itype(6'h08, 5'd0, 5'd0, 16'd7), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h28, 1'b0, 5'd0, 32'h0);
        step({6'h02, 26'h20}, 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h80, 1'b1, 5'd12, 32'h100);
        step(itype(6'h08, 5'd0, 5'd12, 16'h0100), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h84, 1'b0, 5'd0, 32'h0);
        step(rtype(5'd12, 5'd0, 5'd0, 5'd0, 6'h08), 0, 0, 32'h0, 2, 1'b0);
        expect_i(32'h100, 1'b0, 5'd0, 32'h0);
        step({6'h3F, 26'h0}, 0, 0, 32'h0, 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_quiet", {imem_req, retire, halted}, 3'b001);
        end

        // Reset while a store is waiting on its acknowledge.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rerst_req", {imem_req, imem_addr, halted}, {1'b1, 32'h0, 1'b0});
        regnum = 5'd1;
        #1;
        chk("rerst_r1", reggg, 32'h0);
        imem_valid = 1'b1;
        imem_data  = itype(6'h2B, 5'd0, 5'd1, 16'd8);
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        chk("mid_mem_req", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b1, 32'd8});
        rst = 1'b1;
        #1;
        chk("mid_mem_drop", dmem_req, 1'b0);
        @(negedge clk);
        chk("mid_mem_rst", {dmem_req, imem_req, retire}, 3'b000);
        rst = 1'b0;
        #1;
        chk("mid_mem_restart", {imem_req, imem_addr, dmem_req}, {1'b1, 32'h0, 1'b0});
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
